// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg: declarations shared by the serial pattern blocks (seq_gen, seq_det).
//   seq_gen_state_t : transmitter FSM states
//   SEQ_PAT_1010    : reference 4-bit pattern used by the detector side
//   seq_clamp_len   : maps an out-of-range length (0 or > w) onto w
// ---------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_gen_state_t;

    localparam logic [3:0] SEQ_PAT_1010 = 4'b1010;

    function automatic int seq_clamp_len(input int len, input int w);
        return (len == 0 || len > w) ? w : len;
    endfunction

endpackage

// File: rtl/seq_gen_cnt.sv
// ---------------------------------------------------------------------------
// seq_gen_cnt: loadable down-counter with zero flag. Decrement holds at zero,
// so the counter never wraps.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i, val_i : load val_i (takes priority over dec_i)
//   dec_i         : decrement by one when non-zero
//   nxt_o         : value the counter takes at the next edge
//   zero_o        : current count is zero
// ---------------------------------------------------------------------------
module seq_gen_cnt #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [N-1:0] val_i,
    input  logic         dec_i,
    output logic [N-1:0] nxt_o,
    output logic         zero_o
);

    logic [N-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - N'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign nxt_o  = cnt_d;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/seq_gen.sv
// ---------------------------------------------------------------------------
// seq_gen: serial pattern transmitter. Latches a pattern of up to W bits and
// sends it MSB-first, one bit per clock, rep times with gap idle cycles
// between repetitions.
//   clk_i, rst_ni  : clock, async active-low reset
//   start_i        : request a transfer (only sampled when not busy)
//   pattern_i      : pattern bits, LSB-aligned; bit len-1 goes first
//   len_i          : bits per repetition (0 or > W means W)
//   rep_i          : repetitions (0 means 1)
//   gap_i          : idle cycles between repetitions
//   abort_i        : synchronous cancel
//   x_o, x_valid_o : serial data and its qualifier
//   sof_o          : first bit of each repetition
//   busy_o         : transfer in progress (SEND/GAP)
//   done_o         : one-cycle pulse after the last bit
// All outputs come straight from flops; they are computed from next-state
// values so that a start sampled at edge k shows its first bit in cycle k+1.
// ---------------------------------------------------------------------------
module seq_gen
    import seq_pkg::*;
#(
    parameter  int W  = 8,
    parameter  int CW = 8,
    localparam int LW = $clog2(W + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [W-1:0]  pattern_i,
    input  logic [LW-1:0] len_i,
    input  logic [CW-1:0] rep_i,
    input  logic [CW-1:0] gap_i,
    input  logic          abort_i,
    output logic          x_o,
    output logic          x_valid_o,
    output logic          sof_o,
    output logic          busy_o,
    output logic          done_o
);

    seq_gen_state_t state_q, state_d;

    logic [W-1:0]  pat_q, pat_d;
    logic [LW-1:0] len_q, len_d, len_in;
    logic [CW-1:0] gap_q, rep_m1;
    logic          accept;

    logic          idx_ld, idx_dec, idx_zero;
    logic [LW-1:0] idx_val, idx_nxt;
    logic          rep_ld, rep_dec, rep_zero;
    logic          gap_ld, gap_dec, gap_zero;
    logic [CW-1:0] gap_val;
    logic [CW-1:0] unused_rep_nxt, unused_gap_nxt;

    logic          x_d, x_valid_d, sof_d, busy_d, done_d;
    logic [W-1:0]  pat_shift;

    // DONE accepts a start just like IDLE, which gives back-to-back transfers
    // with exactly one non-busy cycle in between.
    assign accept = (state_q == IDLE || state_q == DONE) && start_i && !abort_i;
    assign len_in = LW'(seq_clamp_len(int'(len_i), W));
    // Repetition counter holds the repetitions still to go after the current one.
    assign rep_m1 = (rep_i == '0) ? '0 : rep_i - CW'(1);

    assign pat_d  = accept ? pattern_i : pat_q;
    assign len_d  = accept ? len_in    : len_q;

    // Bit index within the current repetition.
    seq_gen_cnt #(.N(LW)) u_idx (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (idx_ld),
        .val_i  (idx_val),
        .dec_i  (idx_dec),
        .nxt_o  (idx_nxt),
        .zero_o (idx_zero)
    );

    // Remaining repetitions.
    seq_gen_cnt #(.N(CW)) u_rep (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (rep_ld),
        .val_i  (rep_m1),
        .dec_i  (rep_dec),
        .nxt_o  (unused_rep_nxt),
        .zero_o (rep_zero)
    );

    // Remaining idle cycles of the current gap (loaded with gap-1).
    seq_gen_cnt #(.N(CW)) u_gap (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (gap_ld),
        .val_i  (gap_val),
        .dec_i  (gap_dec),
        .nxt_o  (unused_gap_nxt),
        .zero_o (gap_zero)
    );

    // State register and latched transfer parameters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pat_q <= pattern_i;
                len_q <= len_in;
                gap_q <= gap_i;
            end
        end
    end

    // Next-state and counter control.
    always_comb begin
        state_d = state_q;
        idx_ld  = 1'b0;
        idx_val = len_q - LW'(1);
        idx_dec = 1'b0;
        rep_ld  = 1'b0;
        rep_dec = 1'b0;
        gap_ld  = 1'b0;
        gap_val = gap_q - CW'(1);
        gap_dec = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = SEND;
                    idx_ld  = 1'b1;
                    idx_val = len_in - LW'(1);
                    rep_ld  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (!idx_zero) begin
                    idx_dec = 1'b1;
                end else if (rep_zero) begin
                    state_d = DONE;
                end else begin
                    rep_dec = 1'b1;
                    if (gap_q != '0) begin
                        state_d = GAP;
                        gap_ld  = 1'b1;
                    end else begin
                        idx_ld  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (gap_zero) begin
                    state_d = SEND;
                    idx_ld  = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode, looking at the state and index of the coming cycle.
    always_comb begin
        pat_shift = pat_d >> idx_nxt;
        x_d       = (state_d == SEND) && pat_shift[0];
        x_valid_d = (state_d == SEND);
        sof_d     = (state_d == SEND) && (idx_nxt == len_d - LW'(1));
        busy_d    = (state_d == SEND) || (state_d == GAP);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_o       <= 1'b0;
            x_valid_o <= 1'b0;
            sof_o     <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            x_o       <= x_d;
            x_valid_o <= x_valid_d;
            sof_o     <= sof_d;
            busy_o    <= busy_d;
            done_o    <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_seq_gen: directed and randomized checks of seq_gen against a cycle list
// built from the transfer rules (bits MSB-first, gaps, final done cycle).
// ---------------------------------------------------------------------------
module tb_seq_gen;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] len = '0;
    logic [7:0] rep = '0;
    logic [7:0] gap = '0;
    logic       x, xv, sof, busy, done;

    int         checks = 0;
    int         errors = 0;
    logic [4:0] exp_q[$];
    int         busy_cnt, det_cnt;
    logic [3:0] sh;

    seq_gen #(.W(8), .CW(8)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .pattern_i (pattern),
        .len_i     (len),
        .rep_i     (rep),
        .gap_i     (gap),
        .abort_i   (abort),
        .x_o       (x),
        .x_valid_o (xv),
        .sof_o     (sof),
        .busy_o    (busy),
        .done_o    (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // {x, x_valid, sof, busy, done}
    function automatic logic [4:0] outs();
        return {x, xv, sof, busy, done};
    endfunction

    // Per-cycle expectation of one transfer, starting with its first bit.
    function automatic void add_model(input logic [7:0] p, input int l, input int r, input int g);
        int le, re;
        le = (l == 0 || l > 8) ? 8 : l;
        re = (r == 0) ? 1 : r;
        for (int k = 0; k < re; k++) begin
            for (int b = 0; b < le; b++)
                exp_q.push_back({p[le-1-b], 1'b1, (b == 0), 1'b1, 1'b0});
            if (k < re - 1)
                for (int j = 0; j < g; j++) exp_q.push_back(5'b00010);
        end
        exp_q.push_back(5'b00001);
    endfunction

    // Walk the expectation list; optionally poke a start with junk inputs
    // while busy (poke_at) or release a held start (drop_at).
    task automatic run_q(input string tag, input int poke_at, input int drop_at);
        busy_cnt = 0;
        det_cnt  = 0;
        sh       = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(tag, 32'(outs()), 32'(exp_q[i]));
            if (busy) busy_cnt++;
            sh = {sh[2:0], x};
            if (sh == SEQ_PAT_1010) det_cnt++;
            if (i == poke_at) begin
                start   = 1'b1;
                pattern = 8'($urandom);
                len     = 4'($urandom);
                rep     = 8'($urandom);
                gap     = 8'($urandom);
            end else if (i == poke_at + 1 || i == drop_at) begin
                start = 1'b0;
            end
            tick();
        end
        chk({tag, " idle"}, 32'(outs()), 32'd0);
    endtask

    task automatic xfer(input string tag, input logic [7:0] p, input logic [3:0] l,
                        input logic [7:0] r, input logic [7:0] g, input int poke_at);
        exp_q.delete();
        add_model(p, int'(l), int'(r), int'(g));
        pattern = p;
        len     = l;
        rep     = r;
        gap     = g;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        run_q(tag, poke_at, -10);
    endtask

    initial begin
        int n1, le;
        logic [7:0] rp;
        logic [3:0] rl;
        logic [7:0] rr, rg;

        // Reset state
        #2 rst_n = 1'b0;
        tick();
        chk("reset0", 32'(outs()), 32'd0);
        tick();
        chk("reset1", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_reset", 32'(outs()), 32'd0);

        // Basic transfer: 1,0,1,0 then done
        xfer("basic", 8'h0A, 4'd4, 8'd1, 8'd0, -10);

        // Repetition with gaps: 1010 00 1010 00 1010
        xfer("rep3gap2", 8'h0A, 4'd4, 8'd3, 8'd2, -10);
        chk("rep3gap2 busy", 32'(busy_cnt), 32'(3 * 4 + 2 * 2));
        chk("rep3gap2 det", 32'(det_cnt), 32'd3);

        // Clamping
        xfer("len0", 8'hA5, 4'd0, 8'd1, 8'd0, -10);
        xfer("len12", 8'h3C, 4'd12, 8'd1, 8'd0, -10);
        xfer("rep0", 8'h06, 4'd3, 8'd0, 8'd4, -10);

        // Start while busy is ignored
        xfer("busy_start", 8'hC9, 4'd8, 8'd2, 8'd1, 2);

        // Abort in the 3rd SEND cycle
        pattern = 8'hA5; len = 4'd8; rep = 8'd1; gap = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort c0", 32'(outs()), 32'(5'b11110));
        tick();
        tick();
        chk("abort c2", 32'(outs()), 32'(5'b11010));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort idle", 32'(outs()), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort nodone", 32'(outs()), 32'd0);
        end

        // start + abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort", 32'(outs()), 32'd0);
        tick();
        chk("start_abort2", 32'(outs()), 32'd0);

        // Back-to-back with start held high
        exp_q.delete();
        add_model(8'h0D, 4, 2, 1);
        n1 = exp_q.size();
        add_model(8'h0D, 4, 2, 1);
        pattern = 8'h0D; len = 4'd4; rep = 8'd2; gap = 8'd1;
        start = 1'b1;
        tick();
        run_q("b2b", -10, n1);

        // Counter extremes
        xfer("rep255", 8'h01, 4'd1, 8'd255, 8'd0, -10);
        xfer("gap255", 8'h02, 4'd2, 8'd2, 8'd255, -10);

        // Reset asserted mid-GAP
        pattern = 8'h05; len = 4'd3; rep = 8'd2; gap = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre_rst gap", 32'(outs()), 32'(5'b00010));
        #2 rst_n = 1'b0;
        #1;
        chk("async rst", 32'(outs()), 32'd0);
        tick();
        chk("rst held", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst idle", 32'(outs()), 32'd0);
        xfer("after_rst", 8'h96, 4'd5, 8'd2, 8'd1, -10);

        // Randomized transfers
        for (int t = 0; t < 16; t++) begin
            rp = 8'($urandom);
            rl = 4'($urandom_range(0, 15));
            rr = 8'($urandom_range(0, 4));
            rg = 8'($urandom_range(0, 3));
            le = (rl == 0 || rl > 8) ? 8 : int'(rl);
            xfer("rand", rp, rl, rr, rg, (le >= 2 && $urandom_range(0, 1) == 1) ? 1 : -10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern transmitter: the source side of the `seq_det` serial bit interface. It latches a pattern of up to W bits, emits it MSB-first on one bit per clock, and repeats it a programmable number of times with programmable idle gaps. It also drives framing and status strobes. It sits in front of `seq_det`, driving its `x` input, and is the standard stimulus/traffic source for detector blocks.

## Interface
Parameters:
- `W`, 8: maximum pattern width in bits.
- `CW`, 8: width of the repeat and gap counters.
- `LW`, `$clog2(W+1)`: width of `len` (derived, not overridden).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request a transfer; sampled only while `busy`=0.
- `pattern`  in  W  pattern bits, LSB-aligned; bit `len-1` is sent first.
- `len`  in  LW  bits per repetition, 1..W; 0 or >W is clamped to W.
- `rep`  in  CW  number of repetitions; 0 is treated as 1.
- `gap`  in  CW  idle cycles between consecutive repetitions (none after the last).
- `abort`  in  1  synchronous cancel.
- `x`  out  1  serial data.
- `x_valid`  out  1  `x` carries a pattern bit this cycle.
- `sof`  out  1  first bit of each repetition.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse after the last bit of the last repetition.

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- **IDLE:**
  - If `start`=1 and `abort`=0, latch `pattern`, clamped `len`, normalised `rep` and `gap`.
  - Load bit index = `len`-1 and repetition counter = `rep`, then go to SEND.
- **SEND:**
  - Drive `x` = latched `pattern[idx]` with `x_valid`=1.
  - Drive `sof`=1 when idx = `len`-1.
  - Decrement idx each cycle.
  - At idx=0: decrement the repetition counter.
  - If repetitions remain, go to GAP when `gap`>0, otherwise back to SEND with idx reloaded.
  - If no repetitions remain, go to DONE.
- **GAP:** drive `x`=0 and `x_valid`=0 for exactly `gap` cycles, then return to SEND with idx reloaded.
- **DONE:**
  - `done`=1, `busy`=0, `x`=0 for one cycle.
  - A `start` here is accepted exactly as in IDLE (goes to SEND); otherwise go to IDLE.
- `busy`=1 in SEND and GAP only.
- Inputs `pattern`, `len`, `rep` and `gap` are ignored while `busy`=1. A `start` while `busy`=1 is dropped.
- **abort:**
  - In SEND or GAP: go to IDLE at the next edge, `x`/`x_valid` low, no `done` pulse.
  - Simultaneous with `start` in IDLE or DONE: abort wins and nothing starts.
- **Reset:** asserting `rst` at any time, including mid-transfer, immediately forces IDLE and drives all outputs to 0. The latched pattern is cleared.

## Timing
- All outputs are registered.
- Reset values: `x`=0, `x_valid`=0, `sof`=0, `busy`=0, `done`=0.
- Latency: `start` sampled at edge k puts the first bit on `x` (with `sof`, `x_valid` and `busy` all 1) during cycle k+1.
- Busy duration: `rep`·`len` + (`rep`-1)·`gap` cycles.
- `done` is high in the cycle immediately after the last bit.
- Back-to-back: `start` held high through DONE gives exactly one idle cycle between transfers.
- Counters never wrap. `rep` = 2^CW-1 and `gap` = 2^CW-1 must run to completion correctly.

## Structure
- Shared package `seq_pkg` holds:
  - the state enum `seq_gen_state_t` (IDLE, SEND, GAP, DONE);
  - constant `SEQ_PAT_1010` = 4'b1010;
  - the helper function for `len` clamping.
- `seq_det` uses the same constant.
- One sub-module, `seq_gen_cnt`: a loadable down-counter with a zero flag. It is instantiated three times: bit index, repetition count, gap count.

## Test plan
- Reset and basic transfer:
  - Stimulus: `rst`=0 for 2 cycles, then `pattern`=8'h0A, `len`=4, `rep`=1, `gap`=0, `start` pulse at edge k.
  - Required: `x` = 1,0,1,0 in cycles k+1..k+4; `sof` only in k+1; `done` in k+5; all outputs 0 during reset.
- Repetition with gaps:
  - Stimulus: `rep`=3, `gap`=2, pattern 1010; feed `x` into `seq_det`.
  - Required: x = 1010 00 1010 00 1010; `busy` for 16 cycles; `seq_det` `out` pulses exactly 3 times.
- Clamping:
  - Stimulus: `len`=0 with `pattern`=8'hA5.
  - Required: 8 bits 1,0,1,0,0,1,0,1 are sent.
  - Stimulus: `rep`=0.
  - Required: one repetition is sent.
- Abort and contention:
  - Stimulus: `abort` in the 3rd SEND cycle.
  - Required: IDLE next cycle, no `done`.
  - Stimulus: `start` and `abort` high together in IDLE.
  - Required: `busy` stays 0.
  - Stimulus: `start` while `busy`.
  - Required: ignored; the transfer is unaltered.
- Back-to-back and mid-transfer reset:
  - Stimulus: `start` held high.
  - Required: one-cycle DONE gap between transfers.
  - Stimulus: `rst` asserted mid-GAP.
  - Required: outputs 0 asynchronously; a fresh transfer afterwards is correct.
